// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, X-stage forwarding and D flush control for the 5-stage core
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             d_valid_i,
  input  logic [4:0]       d_rs1_i,
  input  logic [4:0]       d_rs2_i,
  input  logic             d_rs1_used_i,
  input  logic             d_rs2_used_i,
  input  logic [4:0]       d_rd_i,
  input  logic             d_rd_wen_i,
  input  logic             d_is_load_i,
  input  logic             x_flush_i,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             bubble_x_o,
  output logic             flush_d_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic       x_valid, x_wen, x_is_load, x_rs1_used, x_rs2_used;
  logic [4:0] x_rd, x_rs1, x_rs2;
  logic       m_valid, m_wen, m_is_load;
  logic [4:0] m_rd;
  // W never needs its load flag: by then the data is in the writeback mux either way.
  logic       w_valid, w_wen;
  logic [4:0] w_rd;

  logic x_writing, m_writing, w_writing, lu;

  assign x_writing = x_valid & x_wen & (x_rd != 5'd0);
  assign m_writing = m_valid & m_wen & (m_rd != 5'd0);
  assign w_writing = w_valid & w_wen & (w_rd != 5'd0);

  assign lu = x_writing & x_is_load & d_valid_i &
              ((d_rs1_used_i & (d_rs1_i == x_rd)) | (d_rs2_used_i & (d_rs2_i == x_rd)));

  // A flush makes the D instruction wrong-path, so it overrides any load-use stall.
  assign flush_d_o  = x_flush_i;
  assign bubble_x_o = x_flush_i | lu;
  assign stall_f_o  = lu & ~x_flush_i;
  assign stall_d_o  = lu & ~x_flush_i;

  always_comb begin
    fwd_a_o = 2'b00;
    fwd_b_o = 2'b00;
    if (x_valid && x_rs1_used) begin
      if (m_writing && !m_is_load && (m_rd == x_rs1)) fwd_a_o = 2'b01;
      else if (w_writing && (w_rd == x_rs1))          fwd_a_o = 2'b10;
    end
    if (x_valid && x_rs2_used) begin
      if (m_writing && !m_is_load && (m_rd == x_rs2)) fwd_b_o = 2'b01;
      else if (w_writing && (w_rd == x_rs2))          fwd_b_o = 2'b10;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      x_valid    <= 1'b0;
      x_wen      <= 1'b0;
      x_is_load  <= 1'b0;
      x_rs1_used <= 1'b0;
      x_rs2_used <= 1'b0;
      x_rd       <= 5'd0;
      x_rs1      <= 5'd0;
      x_rs2      <= 5'd0;
      m_valid    <= 1'b0;
      m_wen      <= 1'b0;
      m_is_load  <= 1'b0;
      m_rd       <= 5'd0;
      w_valid    <= 1'b0;
      w_wen      <= 1'b0;
      w_rd       <= 5'd0;
    end else begin
      w_valid   <= m_valid;
      w_wen     <= m_wen;
      w_rd      <= m_rd;
      m_valid   <= x_valid;
      m_wen     <= x_wen;
      m_is_load <= x_is_load;
      m_rd      <= x_rd;
      if (bubble_x_o) begin
        x_valid    <= 1'b0;
        x_wen      <= 1'b0;
        x_is_load  <= 1'b0;
        x_rs1_used <= 1'b0;
        x_rs2_used <= 1'b0;
        x_rd       <= 5'd0;
        x_rs1      <= 5'd0;
        x_rs2      <= 5'd0;
      end else begin
        x_valid    <= d_valid_i;
        x_wen      <= d_rd_wen_i;
        x_is_load  <= d_is_load_i;
        x_rs1_used <= d_rs1_used_i;
        x_rs2_used <= d_rs2_used_i;
        x_rd       <= d_rd_i;
        x_rs1      <= d_rs1_i;
        x_rs2      <= d_rs2_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
    end else if (stall_d_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core (F/D/X/M/W). It tracks the destination register, write-enable and load flag of each in-flight instruction in X, M and W. From that state it generates:
- F/D stall and X-bubble insertion for load-use hazards,
- operand forwarding selects for the X-stage ALU,
- D-stage flush on a taken branch/jump resolved in X.

It sits beside `control`, consuming the decode-stage fields and driving the datapath's stall/flush enables and forwarding muxes.

## Interface
Parameters:
- `CNT_W`, 16, width of the saturating stall-cycle counter.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `d_valid_i`  in  1  D stage holds a valid instruction.
- `d_rs1_i`  in  5  D-stage rs1 address.
- `d_rs2_i`  in  5  D-stage rs2 address.
- `d_rs1_used_i`  in  1  D instruction reads rs1.
- `d_rs2_used_i`  in  1  D instruction reads rs2.
- `d_rd_i`  in  5  D-stage rd address.
- `d_rd_wen_i`  in  1  D instruction writes rd.
- `d_is_load_i`  in  1  D instruction is a LOAD.
- `x_flush_i`  in  1  taken branch/jump resolved in X this cycle.
- `stall_f_o`  out  1  hold PC/F register.
- `stall_d_o`  out  1  hold F/D register.
- `bubble_x_o`  out  1  D/X register loads a NOP instead of D.
- `flush_d_o`  out  1  kill F/D register contents (load NOP).
- `fwd_a_o`  out  2  X operand A select: 00 regfile, 01 M-stage ALU result, 10 W-stage writeback data.
- `fwd_b_o`  out  2  X operand B select, same encoding.
- `stall_cnt_o`  out  CNT_W  number of load-use stall cycles since reset, saturating.

## Operation
- Internal stage records for X, M and W: `valid`, `rd`, `wen`, `is_load`. The X record also holds `rs1`, `rs2`, `rs1_used` and `rs2_used`.
- A record is "writing" when `valid & wen & rd != 0`. Register x0 never causes a hazard or a forward.
- **Load-use hazard (lu):**
  - Condition: X record writing with `is_load=1`, and `d_valid_i`, and a match `(d_rs1_used_i & d_rs1_i == x.rd) | (d_rs2_used_i & d_rs2_i == x.rd)`.
  - Response: `stall_f_o=1`, `stall_d_o=1`, `bubble_x_o=1`.
- **Flush:**
  - `x_flush_i=1` gives `flush_d_o=1` and `bubble_x_o=1`, and forces `stall_f_o=stall_d_o=0`. Flush has priority over lu because the D instruction is wrong-path.
  - The X-stage instruction itself still advances to M.
- **Record update each clock:**
  - W ← M and M ← X, always.
  - If `bubble_x_o`, X ← invalid. Otherwise X ← D fields with `valid=d_valid_i`.
- **Forwarding, per operand, for the X record** (rs = `x.rs1` with `rs1_used`, or `x.rs2` with `rs2_used`):
  - M writing, `!m.is_load`, `m.rd==rs` → 01.
  - Else W writing, `w.rd==rs` → 10.
  - Else 00.
  - M has priority over W.
  - An unused operand or an invalid X record gives 00.
  - An M-stage load matching rs falls through to the W check; the lu stall guarantees it cannot occur.
- All outputs are combinational from the registered records plus the D-stage inputs. There are no internal handshakes.
- **Counter:** `stall_cnt_o` increments by 1 on each clock edge where `stall_d_o=1`. It saturates at all-ones, with no wrap.

## Timing
- Reset (async assert, sync to clock edge on deassert):
  - all records invalid with fields 0,
  - `stall_cnt_o=0`,
  - therefore `stall_f_o=stall_d_o=bubble_x_o=flush_d_o=0` and `fwd_a_o=fwd_b_o=00`.
- Reset mid-stall clears all records, so the stall drops in the same cycle reset asserts.
- A load-use stall lasts exactly 1 cycle:
  - In cycle n, the load is in X and the dependent instruction in D; stall is asserted.
  - In cycle n+1, the load is in M and the bubble in X; the stall is released because X is no longer a load.
  - In cycle n+2, the dependent instruction is in X and gets fwd=10 from W.
- Back-to-back dependent ALU ops: the consumer in X sees fwd=01 with zero stall.
- Flush and lu in the same cycle: flush only. That cycle does not increment `stall_cnt_o`.
- Decision latency is 0 cycles, because outputs are combinational. Record state is visible one cycle after the D inputs are sampled.

## Test plan
- **ALU→ALU dependency:**
  - Stimulus: `add x5,x1,x2` then `sub x6,x5,x3`.
  - Required: when `sub` is in X, `fwd_a_o=01`, `fwd_b_o=00`, no stall.
- **Distance-2 dependency:**
  - Stimulus: `add x5`, an unrelated instruction, then `or x7,x4,x5`.
  - Required: `fwd_b_o=10` for `or` in X.
  - Same sequence with rd=x0: all selects 00.
- **Load-use:**
  - Stimulus: `lw x8` then `add x9,x8,x8`.
  - Required:
    - exactly 1 cycle with `stall_f_o=stall_d_o=bubble_x_o=1`,
    - then `fwd_a_o=fwd_b_o=10`,
    - `stall_cnt_o` increments from 0 to 1.
- **Flush vs stall:**
  - Stimulus: `lw x8` in X with `add x9,x8,x1` in D, and `x_flush_i=1` in the same cycle.
  - Required: `flush_d_o=1`, `bubble_x_o=1`, `stall_*=0`, `stall_cnt_o` unchanged.
- **Counter saturation and reset:**
  - Stimulus: with CNT_W=4, force 17 load-use stalls.
  - Required: `stall_cnt_o=4'hF`.
  - Then assert `rst_n_i` low mid-stall: all outputs go to 0 immediately, asynchronously.
